// File: rtl/xil_fifo_ctl_1024x16.sv
// FWFT FIFO controller for the 1024x16 dual-port block RAM.
// Two-entry output register stage hides the RAM's one-cycle read latency.
module xil_fifo_ctl_1024x16 #(
    parameter int unsigned AFULL_LEVEL  = 1020,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [15:0] i_wdata,
    output logic        o_ready,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [15:0] o_rdata,
    output logic [10:0] o_level,
    output logic        o_almost_full,
    output logic        o_almost_empty,
    output logic        o_mem_en0,
    output logic [1:0]  o_mem_wen0,
    output logic [9:0]  o_mem_adr0,
    output logic [15:0] o_mem_wdata0,
    output logic        o_mem_en1,
    output logic [9:0]  o_mem_adr1,
    input  logic [15:0] i_mem_rdata1
);

    localparam logic [10:0] MEM_DEPTH = 11'd1024;
    localparam logic [10:0] AFULL_L   = 11'(AFULL_LEVEL);
    localparam logic [10:0] AEMPTY_L  = 11'(AEMPTY_LEVEL);

    logic [9:0]  wr_ptr, rd_ptr;
    logic [10:0] mem_cnt, mem_cnt_n;
    logic        inflight;
    logic [1:0]  out_cnt, out_cnt_n, after_pop;
    logic [15:0] slot0, slot1, slot0_n, slot1_n;
    logic        ready_q;
    logic [10:0] level_q;
    logic        push_acc, pop_acc, issue;

    always_comb begin
        push_acc  = i_push && ready_q;
        pop_acc   = i_pop && (out_cnt != 2'd0);
        // issue only if the output stage still has room once this cycle's pop lands
        issue     = (mem_cnt != 11'd0) &&
                    ((3'(out_cnt) + 3'(inflight) - 3'(pop_acc)) < 3'd2);
        mem_cnt_n = mem_cnt + 11'(push_acc) - 11'(issue);

        after_pop = out_cnt - 2'(pop_acc);
        slot0_n   = slot0;
        slot1_n   = slot1;
        if (pop_acc)
            slot0_n = slot1;
        if (inflight) begin
            if (after_pop == 2'd0)
                slot0_n = i_mem_rdata1;
            else
                slot1_n = i_mem_rdata1;
        end
        out_cnt_n = after_pop + 2'(inflight);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            out_cnt  <= '0;
            slot0    <= '0;
            slot1    <= '0;
            ready_q  <= 1'b1;
            level_q  <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 10'd1;
            if (issue)
                rd_ptr <= rd_ptr + 10'd1;
            inflight <= issue;
            mem_cnt  <= mem_cnt_n;
            out_cnt  <= out_cnt_n;
            slot0    <= slot0_n;
            slot1    <= slot1_n;
            ready_q  <= (mem_cnt_n != MEM_DEPTH);
            level_q  <= mem_cnt_n + 11'(issue) + 11'(out_cnt_n);
        end
    end

    always_comb begin
        o_ready        = ready_q;
        o_valid        = (out_cnt != 2'd0);
        o_rdata        = slot0;
        o_level        = level_q;
        o_almost_full  = (level_q >= AFULL_L);
        o_almost_empty = (level_q <= AEMPTY_L);
        o_mem_en0      = push_acc;
        o_mem_wen0     = {2{push_acc}};
        o_mem_adr0     = wr_ptr;
        o_mem_wdata0   = i_wdata;
        o_mem_en1      = issue;
        o_mem_adr1     = rd_ptr;
    end

endmodule

// File: tb/tb_xil_fifo_ctl_1024x16.sv
// Bench for xil_fifo_ctl_1024x16: behavioural RAM, queue-based FIFO reference, directed table plus random traffic.
module tb_xil_fifo_ctl_1024x16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_push = 1'b0;
    logic [15:0] i_wdata = '0;
    logic        o_ready;
    logic        i_pop = 1'b0;
    logic        o_valid;
    logic [15:0] o_rdata;
    logic [10:0] o_level;
    logic        o_almost_full, o_almost_empty;
    logic        o_mem_en0;
    logic [1:0]  o_mem_wen0;
    logic [9:0]  o_mem_adr0;
    logic [15:0] o_mem_wdata0;
    logic        o_mem_en1;
    logic [9:0]  o_mem_adr1;
    logic [15:0] i_mem_rdata1;

    xil_fifo_ctl_1024x16 #(.AFULL_LEVEL(1020), .AEMPTY_LEVEL(2)) dut (
        .clk(clk), .rst(rst),
        .i_push(i_push), .i_wdata(i_wdata), .o_ready(o_ready),
        .i_pop(i_pop), .o_valid(o_valid), .o_rdata(o_rdata),
        .o_level(o_level), .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
        .o_mem_en0(o_mem_en0), .o_mem_wen0(o_mem_wen0), .o_mem_adr0(o_mem_adr0),
        .o_mem_wdata0(o_mem_wdata0), .o_mem_en1(o_mem_en1), .o_mem_adr1(o_mem_adr1),
        .i_mem_rdata1(i_mem_rdata1)
    );

    always #5 clk = ~clk;

    // RAM with registered read (old data on collision)
    logic [15:0] ram [1024];
    always @(posedge clk) begin
        if (o_mem_en1)
            i_mem_rdata1 <= ram[o_mem_adr1];
        if (o_mem_en0)
            ram[o_mem_adr0] <= o_mem_wdata0;
    end

    typedef struct {
        logic [15:0] d;
        int unsigned t;
    } ent_t;
    ent_t q[$];

    int unsigned cyc_n  = 0;
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc_n);
        end
    endtask

    // One clock cycle: check state against the queue model, drive inputs, update model.
    task automatic cyc(input logic p, input logic [15:0] d, input logic pp,
                       output logic s_valid, output logic [15:0] s_rdata,
                       output logic [10:0] s_level, output logic s_en1);
        logic acc, pa, exp_v;
        @(negedge clk);
        chk("level", 32'(o_level), q.size());
        exp_v = (q.size() > 0) && (cyc_n - q[0].t >= 3);
        chk("valid", 32'(o_valid), 32'(exp_v));
        if (exp_v)
            chk("rdata", 32'(o_rdata), 32'(q[0].d));
        if (q.size() < 1024)
            chk("ready", 32'(o_ready), 32'd1);
        else if (q.size() == 1026)
            chk("ready_full", 32'(o_ready), 32'd0);
        chk("afull", 32'(o_almost_full), 32'(q.size() >= 1020));
        chk("aempty", 32'(o_almost_empty), 32'(q.size() <= 2));
        i_push = p; i_wdata = d; i_pop = pp;
        #1;
        acc = p && o_ready;
        pa  = pp && o_valid;
        chk("mem_en0", 32'(o_mem_en0), 32'(acc));
        chk("mem_wen0", 32'(o_mem_wen0), {30'd0, acc, acc});
        if (acc) begin
            chk("mem_adr0", 32'(o_mem_adr0), wr_cnt % 1024);
            chk("mem_wdata0", 32'(o_mem_wdata0), 32'(d));
        end
        if (o_mem_en1) begin
            chk("mem_adr1", 32'(o_mem_adr1), rd_cnt % 1024);
            rd_cnt++;
        end
        s_valid = o_valid; s_rdata = o_rdata; s_level = o_level; s_en1 = o_mem_en1;
        @(posedge clk);
        if (pa && q.size() > 0)
            void'(q.pop_front());
        if (acc) begin
            q.push_back('{d, cyc_n});
            wr_cnt++;
        end
        cyc_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_push = 1'b0; i_pop = 1'b0;
        @(posedge clk);
        q.delete();
        wr_cnt = 0; rd_cnt = 0;
        cyc_n++;
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        logic v, e; logic [15:0] r; logic [10:0] l;
        for (int i = 0; i < 3000 && q.size() > 0; i++)
            cyc(1'b0, 16'h0, 1'b1, v, r, l, e);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    typedef struct {
        logic        push;
        logic [15:0] wdata;
        logic        pop;
        logic        exp_valid;
        logic        chk_rdata;
        logic [15:0] exp_rdata;
        logic [10:0] exp_level;
        logic        exp_en1;
    } vec_t;
    vec_t vecs[5];

    initial begin
        logic v, e; logic [15:0] r; logic [10:0] l;
        int unsigned n, budget;

        vecs[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b1, 16'h0000, 11'd0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA5A5, 11'd1, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b0};

        // Single word, table driven
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(vecs[i].push, vecs[i].wdata, vecs[i].pop, v, r, l, e);
            chk("tbl_valid", 32'(v), 32'(vecs[i].exp_valid));
            chk("tbl_level", 32'(l), 32'(vecs[i].exp_level));
            chk("tbl_en1", 32'(e), 32'(vecs[i].exp_en1));
            if (vecs[i].chk_rdata)
                chk("tbl_rdata", 32'(r), 32'(vecs[i].exp_rdata));
        end

        // Pop on empty does nothing
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 16'h0, 1'b1, v, r, l, e);

        // Fill to 1026, extra push ignored, drain in order
        do_reset();
        n = 0;
        for (int i = 0; i < 1200 && q.size() < 1026; i++) begin
            cyc(1'b1, 16'(q.size()), 1'b0, v, r, l, e);
            n++;
        end
        chk("fill_count", q.size(), 32'd1026);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'hFFFF, 1'b0, v, r, l, e);
        chk("full_level", 32'(l), 32'd1026);
        drain();

        // Streaming push/pop every cycle after 3-cycle prime
        do_reset();
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 16'(k), 1'b0, v, r, l, e);
        for (int k = 3; k < 3000; k++) begin
            cyc(1'b1, 16'(k), 1'b1, v, r, l, e);
            if (k % 500 == 0) begin
                chk("stream_valid", 32'(v), 32'd1);
                chk("stream_level", 32'(l), 32'd3);
            end
        end
        drain();

        // Random backpressure
        do_reset();
        n = wr_cnt; budget = 0;
        while (wr_cnt - n < 5000 && budget < 40000) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), v, r, l, e);
            budget++;
        end
        chk("random_accepted", wr_cnt - n, 32'd5000);
        drain();

        // Reset mid-stream with a read in flight
        do_reset();
        for (int i = 0; i < 500; i++)
            cyc(1'b1, 16'(i + 7), 1'b0, v, r, l, e);
        cyc(1'b1, 16'hBEEF, 1'b1, v, r, l, e);
        chk("pre_reset_level", q.size(), 32'd500);
        do_reset();
        cyc(1'b1, 16'h1234, 1'b0, v, r, l, e);
        chk("post_reset_valid", 32'(v), 32'd0);
        chk("post_reset_level", 32'(l), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 16'h0, 1'b0, v, r, l, e);
            chk("post_reset_wait", 32'(v), 32'd0);
        end
        cyc(1'b0, 16'h0, 1'b1, v, r, l, e);
        chk("post_reset_valid3", 32'(v), 32'd1);
        chk("post_reset_rdata", 32'(r), 32'h1234);
        cyc(1'b0, 16'h0, 1'b0, v, r, l, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
